uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte-stream requesters. Round-robin grant
//  per packet (packet = bytes up to and including one flagged i_last), capped at MAX_BURST
//  bytes per grant. Sequences the transmitter: one o_tx_start per byte, next byte only
//  after i_tx_done. Sits between on-chip sources (status, debug, echo) and the UART Tx.
// PARAMETERS
//  NUM_REQ    4   number of requesters, 2..8
//  MAX_BURST  16  max bytes per grant before forced release, >=1
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst          in   1          asynchronous, active-high reset
//  i_req        in   NUM_REQ    requester r has a byte on i_byte[r]; held until o_ack[r]
//  i_byte       in   NUM_REQ*8  flattened bytes, requester r at [8r+7:8r]
//  i_last       in   NUM_REQ    byte on i_byte[r] is last of packet; qualified by i_req[r]
//  o_ack        out  NUM_REQ    one-cycle pulse: byte of requester r taken
//  o_grant      out  NUM_REQ    one-hot current owner; all-zero when idle
//  o_tx_start   out  1          one-cycle pulse: transmitter loads o_tx_byte
//  o_tx_byte    out  8          byte to transmit, valid with o_tx_start, held until next start
//  i_tx_busy    in   1          transmitter shifting a frame
//  i_tx_done    in   1          one-cycle pulse at end of stop bit
//  o_burst_cut  out  1          one-cycle pulse: grant released by MAX_BURST, not i_last
// BEHAVIOUR
//  - Reset: state IDLE; o_ack, o_grant, o_tx_start, o_burst_cut = 0; o_tx_byte = 8'h00;
//    ptr = NUM_REQ-1 (requester 0 wins first); burst_cnt = 0. Tx not aborted by reset.
//  - All outputs registered. FSM states IDLE, SEND, WAIT.
//  - IDLE: if |i_req: pick first set bit searching ptr+1, ptr+2, ... mod NUM_REQ; register
//    o_grant, clear burst_cnt -> SEND. Else stay.
//  - SEND (owner g): if !i_req[g] -> IDLE, o_grant=0, ptr=g (abandoned packet).
//    elif i_tx_busy -> stay. else: o_tx_start=1, o_ack[g]=1, o_tx_byte=i_byte[g],
//    burst_cnt++, done_flag = i_last[g]; cut_flag = !i_last[g] && burst_cnt==MAX_BURST-1 -> WAIT.
//  - WAIT: on i_tx_done: if done_flag|cut_flag -> IDLE, o_grant=0, ptr=g, o_burst_cut=cut_flag;
//    else -> SEND. i_tx_done outside WAIT is ignored.
//  - Latency: i_req rises in IDLE at cycle 0 -> o_grant cycle 1 -> o_tx_start/o_ack cycle 2
//    (tx idle). Back-to-back bytes: next o_tx_start 2 cycles after i_tx_done.
//  - Requester updates i_byte/i_last/i_req in the cycle o_ack is high; it is not resampled
//    until SEND. Non-owner requests are held off, never acked.
//  - burst_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST. ptr width $clog2(NUM_REQ).
//  - Simultaneous i_tx_done and grant release: release wins, IDLE arbitrates next cycle
//    (one dead cycle between packets; fairness over throughput).
//  - rst mid-packet: immediate IDLE, outputs cleared; first post-reset start waits !i_tx_busy.
// STRUCTURE
//  - uart_pkg: typedef byte_t (logic [7:0]); enum arb_state_t {IDLE, SEND, WAIT}.
//  - Sub-module rr_pick: combinational rotate-priority picker (req, ptr -> one-hot, index).
//  - Top: FSM, ptr/burst_cnt/flag registers, byte mux indexed by owner.
// TESTING
//  1 Reset, i_req=4'b1111 all i_last=1 -> grants 0,1,2,3,0 in order; one byte each.
//  2 req0 only, 3-byte packet 8'h41,8'h42,8'h43 last on 3rd -> tx bytes in order, 3 acks,
//    o_grant=0001 throughout, released after 3rd i_tx_done.
//  3 req1 streams 20 bytes never last, MAX_BURST=16 -> 16 starts, o_burst_cut pulse, req2
//    pending gets grant next; req1 resumes after req2.
//  4 i_tx_busy=1 held 100 cycles in SEND -> no o_tx_start/o_ack until busy drops.
//  5 owner drops i_req after 1 byte (no last) -> IDLE, next requester granted, no extra start.
//  6 assert rst during WAIT -> all outputs 0 same cycle; after release, req3 granted first
//    only if reqs 0..2 idle; start delayed while i_tx_busy=1.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: byte type and arbiter FSM encoding.
package uart_tx_arbiter_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam byte_t BYTE_RESET = 8'h00;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signal bundle around the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_tx_arbiter_pkg::*;

    logic [NUM_REQ-1:0]   i_req;
    logic [NUM_REQ*8-1:0] i_byte;
    logic [NUM_REQ-1:0]   i_last;
    logic [NUM_REQ-1:0]   o_ack;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 o_tx_start;
    byte_t                o_tx_byte;
    logic                 i_tx_busy;
    logic                 i_tx_done;
    logic                 o_burst_cut;

    modport slave (
        input  i_req, i_byte, i_last, i_tx_busy, i_tx_done,
        output o_ack, o_grant, o_tx_start, o_tx_byte, o_burst_cut
    );

    modport master (
        output i_req, i_byte, i_last, i_tx_busy, i_tx_done,
        input  o_ack, o_grant, o_tx_start, o_tx_byte, o_burst_cut
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first set request after ptr (wrapping), as one-hot and index.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    int   cand_s;
    logic hit_s;

    // Scan ptr+1 .. ptr+NUM_REQ and latch the first requester found
    always_comb begin
        idx    = {PTR_W{1'b0}};
        valid  = 1'b0;
        cand_s = 0;
        hit_s  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = (int'(ptr) + i) % NUM_REQ;
            hit_s  = !valid && req[cand_s];
            idx    = hit_s ? PTR_W'(cand_s) : idx;
            valid  = valid | hit_s;
        end
        onehot = valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : {NUM_REQ{1'b0}};
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams: round-robin per packet,
// at most MAX_BURST bytes per grant, one tx start per byte paced by tx_done.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t          state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [PTR_W-1:0]    owner_r;
    logic [CNT_W-1:0]    burst_cnt_r;
    logic                done_flag_r;
    logic                cut_flag_r;
    logic [NUM_REQ-1:0]  ack_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic                tx_start_r;
    byte_t               tx_byte_r;
    logic                burst_cut_r;

    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic                pick_valid_s;
    byte_t               owner_byte_s;
    logic                owner_req_s;
    logic                owner_last_s;
    logic                cut_now_s;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (bus.i_req),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Select the current owner's request, byte and last flag
    always_comb begin
        owner_byte_s = BYTE_RESET;
        owner_req_s  = 1'b0;
        owner_last_s = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            owner_byte_s = (owner_r == PTR_W'(r)) ? bus.i_byte[8*r +: 8] : owner_byte_s;
            owner_req_s  = (owner_r == PTR_W'(r)) ? bus.i_req[r]         : owner_req_s;
            owner_last_s = (owner_r == PTR_W'(r)) ? bus.i_last[r]        : owner_last_s;
        end
        cut_now_s = !owner_last_s && (burst_cnt_r == CNT_W'(MAX_BURST - 1));
    end

    // Arbitration and transmitter sequencing FSM; every output is a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= PTR_W'(NUM_REQ - 1);
            owner_r     <= {PTR_W{1'b0}};
            burst_cnt_r <= {CNT_W{1'b0}};
            done_flag_r <= 1'b0;
            cut_flag_r  <= 1'b0;
            ack_r       <= {NUM_REQ{1'b0}};
            grant_r     <= {NUM_REQ{1'b0}};
            tx_start_r  <= 1'b0;
            tx_byte_r   <= BYTE_RESET;
            burst_cut_r <= 1'b0;
        end else begin
            ack_r       <= {NUM_REQ{1'b0}};
            tx_start_r  <= 1'b0;
            burst_cut_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r     <= pick_onehot_s;
                        owner_r     <= pick_idx_s;
                        burst_cnt_r <= {CNT_W{1'b0}};
                        state_r     <= SEND;
                    end else begin
                        grant_r     <= {NUM_REQ{1'b0}};
                    end
                end
                SEND: begin
                    // A withdrawn request ends the packet early; the owner goes to the back
                    if (!owner_req_s) begin
                        state_r <= IDLE;
                        grant_r <= {NUM_REQ{1'b0}};
                        ptr_r   <= owner_r;
                    end else if (bus.i_tx_busy) begin
                        state_r <= SEND;
                    end else begin
                        tx_start_r  <= 1'b1;
                        ack_r       <= grant_r;
                        tx_byte_r   <= owner_byte_s;
                        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                        done_flag_r <= owner_last_s;
                        cut_flag_r  <= cut_now_s;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_tx_done) begin
                        if (done_flag_r || cut_flag_r) begin
                            state_r     <= IDLE;
                            grant_r     <= {NUM_REQ{1'b0}};
                            ptr_r       <= owner_r;
                            burst_cut_r <= cut_flag_r;
                        end else begin
                            state_r     <= SEND;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= {NUM_REQ{1'b0}};
                end
            endcase
        end
    end

    assign bus.o_ack       = ack_r;
    assign bus.o_grant     = grant_r;
    assign bus.o_tx_start  = tx_start_r;
    assign bus.o_tx_byte   = tx_byte_r;
    assign bus.o_burst_cut = burst_cut_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: fairness, packets, burst cut, busy hold-off,
// abandoned packets and reset in the middle of a frame.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) arb_bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_bus)
    );

    always #5 clk = ~clk;

    task automatic set_byte(input int r, input logic [7:0] b, input logic last);
        arb_bus.i_byte[8*r +: 8] = b;
        arb_bus.i_last[r]        = last;
    endtask

    // Waits (bounded) for the next tx start pulse and reports what came with it
    task automatic wait_start(input int budget, output logic got, output int waited,
                              output logic [7:0] b, output logic [3:0] ack, output logic [3:0] grant);
        got = 1'b0; waited = 0; b = 8'h00; ack = 4'b0000; grant = 4'b0000;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            if (arb_bus.o_tx_start) begin
                got   = 1'b1;
                b     = arb_bus.o_tx_byte;
                ack   = arb_bus.o_ack;
                grant = arb_bus.o_grant;
            end
        end
    endtask

    // Transmitter model: busy for some cycles, then a one-cycle done pulse
    task automatic tx_frame(input int cycles);
        arb_bus.i_tx_busy = 1'b1;
        repeat (cycles) @(negedge clk);
        arb_bus.i_tx_busy = 1'b0;
        arb_bus.i_tx_done = 1'b1;
        @(negedge clk);
        arb_bus.i_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arb_bus.i_req = 4'b0000; arb_bus.i_byte = 32'h0; arb_bus.i_last = 4'b0000;
        arb_bus.i_tx_busy = 1'b0; arb_bus.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arb_bus.o_grant, arb_bus.o_ack} !== 8'h00) begin
            failures++; $display("FAIL reset_grant_ack: got=%h expected=00", {arb_bus.o_grant, arb_bus.o_ack});
        end
        checks++;
        if ({arb_bus.o_tx_start, arb_bus.o_burst_cut, arb_bus.o_tx_byte} !== 10'h000) begin
            failures++; $display("FAIL reset_tx: start=%b cut=%b byte=%h expected 0 0 00",
                                 arb_bus.o_tx_start, arb_bus.o_burst_cut, arb_bus.o_tx_byte);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL idle_no_req: grant=%b expected=0000", arb_bus.o_grant);
        end
    endtask

    task automatic test_round_robin();
        logic got; int n; logic [7:0] b; logic [3:0] ack, gr;
        for (int r = 0; r < NUM_REQ; r++) set_byte(r, 8'(8'hA0 + r), 1'b1);
        arb_bus.i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int exp_r;
            logic [7:0] exp_b;
            exp_r = k % NUM_REQ;
            exp_b = (k == 4) ? 8'hB0 : 8'(8'hA0 + exp_r);
            wait_start(50, got, n, b, ack, gr);
            checks++;
            if (!got || b !== exp_b || ack !== (4'b0001 << exp_r) || gr !== (4'b0001 << exp_r)) begin
                failures++; $display("FAIL rr_turn%0d: got=%b byte=%h ack=%b grant=%b expected byte=%h ack/grant=%b",
                                     k, got, b, ack, gr, exp_b, 4'b0001 << exp_r);
            end
            if (k < 4) set_byte(exp_r, 8'(8'hB0 + exp_r), 1'b1);
            else arb_bus.i_req = 4'b0000;
            tx_frame(3);
        end
        checks++;
        if (arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL rr_release: grant=%b expected=0000", arb_bus.o_grant);
        end
    endtask

    task automatic test_packet();
        logic got; int n; logic [7:0] b; logic [3:0] ack, gr;
        arb_bus.i_last = 4'b0000;
        set_byte(0, 8'h41, 1'b0);
        arb_bus.i_req = 4'b0001;
        @(negedge clk);
        checks++;
        if (arb_bus.o_grant !== 4'b0001 || arb_bus.o_tx_start !== 1'b0) begin
            failures++; $display("FAIL pkt_grant_latency: grant=%b start=%b expected 0001 0", arb_bus.o_grant, arb_bus.o_tx_start);
        end
        @(negedge clk);
        checks++;
        if (arb_bus.o_tx_start !== 1'b1 || arb_bus.o_tx_byte !== 8'h41 || arb_bus.o_ack !== 4'b0001) begin
            failures++; $display("FAIL pkt_byte0: start=%b byte=%h ack=%b expected 1 41 0001",
                                 arb_bus.o_tx_start, arb_bus.o_tx_byte, arb_bus.o_ack);
        end
        set_byte(0, 8'h42, 1'b0);
        tx_frame(3);
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || n !== 1 || b !== 8'h42 || ack !== 4'b0001 || gr !== 4'b0001) begin
            failures++; $display("FAIL pkt_byte1: got=%b wait=%0d byte=%h ack=%b grant=%b expected 1 1 42 0001 0001",
                                 got, n, b, ack, gr);
        end
        set_byte(0, 8'h43, 1'b1);
        tx_frame(4);
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || b !== 8'h43 || ack !== 4'b0001 || gr !== 4'b0001) begin
            failures++; $display("FAIL pkt_byte2: got=%b byte=%h ack=%b grant=%b expected 1 43 0001 0001", got, b, ack, gr);
        end
        arb_bus.i_req = 4'b0000; set_byte(0, 8'h00, 1'b0);
        tx_frame(2);
        checks++;
        if (arb_bus.o_grant !== 4'b0000 || arb_bus.o_burst_cut !== 1'b0) begin
            failures++; $display("FAIL pkt_release: grant=%b cut=%b expected 0000 0", arb_bus.o_grant, arb_bus.o_burst_cut);
        end
    endtask

    task automatic test_burst_cut();
        logic got; int n; logic [7:0] b; logic [3:0] ack, gr;
        int bad;
        bad = 0;
        set_byte(1, 8'h10, 1'b0);
        set_byte(2, 8'hC2, 1'b1);
        arb_bus.i_req = 4'b0110;
        for (int k = 0; k < MAX_BURST; k++) begin
            wait_start(50, got, n, b, ack, gr);
            if (!got || b !== 8'(8'h10 + k) || ack !== 4'b0010) begin
                bad++;
                $display("FAIL burst_byte%0d: got=%b byte=%h ack=%b expected byte=%h ack=0010", k, got, b, ack, 8'(8'h10 + k));
            end
            set_byte(1, 8'(8'h10 + k + 1), 1'b0);
            tx_frame(2);
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (arb_bus.o_burst_cut !== 1'b1 || arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL burst_cut_pulse: cut=%b grant=%b expected 1 0000", arb_bus.o_burst_cut, arb_bus.o_grant);
        end
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || n !== 2 || b !== 8'hC2 || ack !== 4'b0100) begin
            failures++; $display("FAIL burst_next_owner: got=%b wait=%0d byte=%h ack=%b expected 1 2 c2 0100", got, n, b, ack);
        end
        arb_bus.i_req = 4'b0010; set_byte(2, 8'h00, 1'b0);
        tx_frame(2);
        checks++;
        if (arb_bus.o_burst_cut !== 1'b0 || arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL burst_last_release: cut=%b grant=%b expected 0 0000", arb_bus.o_burst_cut, arb_bus.o_grant);
        end
        bad = 0;
        for (int k = MAX_BURST; k < 20; k++) begin
            wait_start(50, got, n, b, ack, gr);
            if (!got || b !== 8'(8'h10 + k) || ack !== 4'b0010) begin
                bad++;
                $display("FAIL burst_resume%0d: got=%b byte=%h ack=%b expected byte=%h ack=0010", k, got, b, ack, 8'(8'h10 + k));
            end
            if (k == 19) arb_bus.i_req = 4'b0000;
            else set_byte(1, 8'(8'h10 + k + 1), (k + 1) == 19);
            tx_frame(2);
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (arb_bus.o_burst_cut !== 1'b0 || arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL burst_resume_release: cut=%b grant=%b expected 0 0000", arb_bus.o_burst_cut, arb_bus.o_grant);
        end
        arb_bus.i_last = 4'b0000;
    endtask

    task automatic test_busy_hold();
        logic got; int n; logic [7:0] b; logic [3:0] ack, gr;
        int early;
        early = 0;
        arb_bus.i_tx_busy = 1'b1;
        set_byte(3, 8'h5A, 1'b1);
        arb_bus.i_req = 4'b1000;
        repeat (100) begin
            @(negedge clk);
            if (arb_bus.o_tx_start || arb_bus.o_ack != 4'b0000) early++;
        end
        checks++;
        if (early !== 0 || arb_bus.o_grant !== 4'b1000) begin
            failures++; $display("FAIL busy_hold: early_starts=%0d grant=%b expected 0 1000", early, arb_bus.o_grant);
        end
        arb_bus.i_tx_busy = 1'b0;
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || n !== 1 || b !== 8'h5A || ack !== 4'b1000) begin
            failures++; $display("FAIL busy_release: got=%b wait=%0d byte=%h ack=%b expected 1 1 5a 1000", got, n, b, ack);
        end
        arb_bus.i_req = 4'b0000; set_byte(3, 8'h00, 1'b0);
        tx_frame(2);
    endtask

    task automatic test_abandon();
        logic got; int n; logic [7:0] b; logic [3:0] ack, gr;
        set_byte(0, 8'h61, 1'b0);
        set_byte(1, 8'h71, 1'b1);
        arb_bus.i_req = 4'b0011;
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || b !== 8'h61 || ack !== 4'b0001) begin
            failures++; $display("FAIL abandon_first: got=%b byte=%h ack=%b expected 1 61 0001", got, b, ack);
        end
        arb_bus.i_req = 4'b0010;
        tx_frame(2);
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || n !== 3 || b !== 8'h71 || ack !== 4'b0010) begin
            failures++; $display("FAIL abandon_next: got=%b wait=%0d byte=%h ack=%b expected 1 3 71 0010", got, n, b, ack);
        end
        arb_bus.i_req = 4'b0000; arb_bus.i_last = 4'b0000;
        tx_frame(2);
        checks++;
        if (arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL abandon_release: grant=%b expected=0000", arb_bus.o_grant);
        end
    endtask

    task automatic test_reset_mid();
        logic got; int n; logic [7:0] b; logic [3:0] ack, gr;
        int early;
        early = 0;
        set_byte(2, 8'h82, 1'b0);
        arb_bus.i_req = 4'b0100;
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || b !== 8'h82 || ack !== 4'b0100) begin
            failures++; $display("FAIL rstmid_start: got=%b byte=%h ack=%b expected 1 82 0100", got, b, ack);
        end
        arb_bus.i_tx_busy = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({arb_bus.o_grant, arb_bus.o_ack} !== 8'h00) begin
            failures++; $display("FAIL rstmid_grant_ack: got=%h expected=00", {arb_bus.o_grant, arb_bus.o_ack});
        end
        checks++;
        if ({arb_bus.o_tx_start, arb_bus.o_burst_cut, arb_bus.o_tx_byte} !== 10'h000) begin
            failures++; $display("FAIL rstmid_tx: start=%b cut=%b byte=%h expected 0 0 00",
                                 arb_bus.o_tx_start, arb_bus.o_burst_cut, arb_bus.o_tx_byte);
        end
        set_byte(2, 8'h92, 1'b1);
        set_byte(3, 8'hA3, 1'b1);
        arb_bus.i_req = 4'b1100;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (arb_bus.o_tx_start) early++;
        end
        checks++;
        if (early !== 0 || arb_bus.o_grant !== 4'b0100) begin
            failures++; $display("FAIL rstmid_hold: early_starts=%0d grant=%b expected 0 0100", early, arb_bus.o_grant);
        end
        arb_bus.i_tx_busy = 1'b0;
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || n !== 1 || b !== 8'h92 || ack !== 4'b0100) begin
            failures++; $display("FAIL rstmid_first: got=%b wait=%0d byte=%h ack=%b expected 1 1 92 0100", got, n, b, ack);
        end
        arb_bus.i_req = 4'b1000;
        tx_frame(2);
        wait_start(50, got, n, b, ack, gr);
        checks++;
        if (!got || n !== 2 || b !== 8'hA3 || ack !== 4'b1000) begin
            failures++; $display("FAIL rstmid_req3: got=%b wait=%0d byte=%h ack=%b expected 1 2 a3 1000", got, n, b, ack);
        end
        arb_bus.i_req = 4'b0000;
        tx_frame(2);
        checks++;
        if (arb_bus.o_grant !== 4'b0000) begin
            failures++; $display("FAIL rstmid_release: grant=%b expected=0000", arb_bus.o_grant);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet();
        test_burst_cut();
        test_busy_hold();
        test_abandon();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
